intmul_rr_sched: RTL

INTMUL_RR_SCHED -- requirements
Module: intmul_rr_sched

---
 rtl/intmul_pkg.sv | 21 ++
 rtl/intmul.sv | 65 ++++++
 rtl/intmul_rr_sched.sv | 137 +++++++++++++
 3 files changed

// File: rtl/intmul_pkg.sv
// Shared multiplier definitions: architecture selector, pipeline configuration and the
// latency those pipeline options produce.
package intmul_pkg;

    typedef enum logic [0:0] {
        USE_STD,
        USE_SHADD
    } mul_mode_e;

    typedef struct packed {
        logic ff_in;
        logic ff_mul;
        logic ff_out;
    } intmul_cfg_t;

    // Each enabled register stage adds one cycle between operands and product.
    function automatic int unsigned intmul_lat(input intmul_cfg_t cfg);
        return {31'd0, cfg.ff_in} + {31'd0, cfg.ff_mul} + {31'd0, cfg.ff_out};
    endfunction

endpackage

// File: rtl/intmul.sv
// Unsigned integer multiplier with optional input, product and output register stages.
// Datapath registers carry no reset; validity is tracked by the caller.
module intmul
    import intmul_pkg::*;
#(
    parameter int unsigned LOGA     = 32,
    parameter int unsigned LOGB     = 32,
    parameter bit          FF_IN    = 1'b1,
    parameter bit          FF_MUL   = 1'b1,
    parameter bit          FF_OUT   = 1'b1,
    parameter mul_mode_e   MUL_MODE = USE_STD
) (
    input  logic                 clk,
    input  logic [LOGA-1:0]      a,
    input  logic [LOGB-1:0]      b,
    output logic [LOGA+LOGB-1:0] c
);

    localparam int unsigned LOGC = LOGA + LOGB;

    logic [LOGA-1:0] a_s;
    logic [LOGB-1:0] b_s;
    logic [LOGC-1:0] prod;
    logic [LOGC-1:0] prod_s;

    if (FF_IN) begin : g_ff_in
        always_ff @(posedge clk) begin
            a_s <= a;
            b_s <= b;
        end
    end else begin : g_no_ff_in
        assign a_s = a;
        assign b_s = b;
    end

    if (MUL_MODE == USE_STD) begin : g_std
        assign prod = LOGC'(a_s) * LOGC'(b_s);
    end else begin : g_shadd
        always_comb begin
            prod = '0;
            for (int unsigned i = 0; i < LOGB; i++) begin
                if (b_s[i]) begin
                    prod = prod + (LOGC'(a_s) << i);
                end
            end
        end
    end

    if (FF_MUL) begin : g_ff_mul
        always_ff @(posedge clk) begin
            prod_s <= prod;
        end
    end else begin : g_no_ff_mul
        assign prod_s = prod;
    end

    if (FF_OUT) begin : g_ff_out
        always_ff @(posedge clk) begin
            c <= prod_s;
        end
    end else begin : g_no_ff_out
        assign c = prod_s;
    end

endmodule

// File: rtl/intmul_rr_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ requesters; a
// {valid, id} tag pipeline matched to the multiplier latency labels each product.
module intmul_rr_sched
    import intmul_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned LOGA     = 32,
    parameter int unsigned LOGB     = 32,
    parameter bit          FF_IN    = 1'b1,
    parameter bit          FF_MUL   = 1'b1,
    parameter bit          FF_OUT   = 1'b1,
    parameter mul_mode_e   MUL_MODE = USE_STD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*LOGA-1:0]     req_a,
    input  logic [NREQ*LOGB-1:0]     req_b,
    output logic                     res_valid,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic [LOGA+LOGB-1:0]     res_c,
    output logic                     busy
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam intmul_cfg_t CFG = '{ff_in: FF_IN, ff_mul: FF_MUL, ff_out: FF_OUT};
    localparam int unsigned LAT = intmul_lat(CFG);

    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_valid;
    logic [IDW-1:0]  idx;
    logic [LOGA-1:0] mul_a;
    logic [LOGB-1:0] mul_b;
    logic [LOGA+LOGB-1:0] mul_c;

    // Search from the pointer, wrapping modulo NREQ; first valid index wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        if (!rst && !hold) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if ({1'b0, ptr_q} + (IDW+1)'(k) >= (IDW+1)'(NREQ)) begin
                    idx = ptr_q + IDW'(k) - IDW'(NREQ);
                end else begin
                    idx = ptr_q + IDW'(k);
                end
                if (!gnt_valid && req_valid[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_id    = idx;
                end
            end
        end
    end

    always_comb begin
        req_ready         = '0;
        req_ready[gnt_id] = gnt_valid;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid) begin
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                mul_a = req_a[i*LOGA +: LOGA];
                mul_b = req_b[i*LOGB +: LOGB];
            end
        end
    end

    intmul #(
        .LOGA     (LOGA),
        .LOGB     (LOGB),
        .FF_IN    (FF_IN),
        .FF_MUL   (FF_MUL),
        .FF_OUT   (FF_OUT),
        .MUL_MODE (MUL_MODE)
    ) u_intmul (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .c   (mul_c)
    );

    assign res_c = mul_c;

    if (LAT == 0) begin : g_lat0
        assign res_valid = gnt_valid;
        assign res_id    = gnt_id;
        assign busy      = 1'b0;
    end else begin : g_tag
        logic [LAT-1:0] tag_v_q;
        logic [IDW-1:0] tag_id_q [LAT];

        // Resetting the tags is what discards products still inside the datapath.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tag_v_q <= '0;
                for (int unsigned i = 0; i < LAT; i++) begin
                    tag_id_q[i] <= '0;
                end
            end else begin
                tag_v_q[0]  <= gnt_valid;
                tag_id_q[0] <= gnt_id;
                for (int unsigned i = 1; i < LAT; i++) begin
                    tag_v_q[i]  <= tag_v_q[i-1];
                    tag_id_q[i] <= tag_id_q[i-1];
                end
            end
        end

        assign res_valid = tag_v_q[LAT-1];
        assign res_id    = tag_id_q[LAT-1];
        assign busy      = |tag_v_q;
    end

endmodule
